grid_io_param: RTL and testbench
================================

GRID_IO_PARAM -- requirements
Module: grid_io_param

Interface
REQ-001 SHALL have parameter NUM_PADS, default 4: number of I/O subtiles, legal range 1..32.
REQ-002 SHALL have parameter CFG_BITS, fixed at 2: configuration bits per pad, where bit0 = dir (1 = input) and bit1 = inv.
REQ-003 SHALL have port prog_clk  in  1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port prog_reset_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port isol_n  in  1: isolation, active-low.
REQ-006 SHALL have port ccff_head  in  1: serial configuration input.
REQ-007 SHALL have port ccff_shift_en  in  1: shift the shadow chain this cycle.
REQ-008 SHALL have port ccff_commit  in  1: request copy of the shadow chain to the active configuration.
REQ-009 SHALL have port ccff_tail  out  1: the last shadow bit.
REQ-010 SHALL have ports gfpga_pad_io_soc_in (in), gfpga_pad_io_soc_out (out) and gfpga_pad_io_soc_dir (out), each NUM_PADS wide: the pad side.
REQ-011 SHALL have ports pin_outpad (in) and pin_inpad (out), each NUM_PADS wide: the fabric side.
REQ-012 SHALL have port cfg_done  out  1: a full frame has been shifted since the last accepted commit.
REQ-013 SHALL have port cfg_err  out  1: sticky flag for a rejected commit.

Function
REQ-014 SHALL define LEN = NUM_PADS*CFG_BITS, plus 1 when GRID_IO_CFG_PARITY_EN is defined.
REQ-015 SHALL, on a cycle with ccff_shift_en=1, perform shadow[0] <= ccff_head and shadow[i] <= shadow[i-1]; ccff_tail SHALL equal shadow[LEN-1].
REQ-016 SHALL map shadow[2p] to the dir bit of pad p and shadow[2p+1] to the inv bit of pad p.
REQ-017 SHALL increment a bit counter on each shift, saturating at LEN; shifting continues after saturation.
REQ-018 SHALL drive cfg_done = (counter == LEN), combinationally from the register.
REQ-019 SHALL accept ccff_commit only when cfg_done=1 (and, with parity enabled, the parity check passes). On acceptance: active config <= shadow, counter <= 0, cfg_err <= 0, all at the next edge (1-cycle latency).
REQ-020 SHALL, on a rejected commit, leave the active config unchanged, set cfg_err <= 1 and leave the counter unchanged.
REQ-021 SHALL, when ccff_shift_en and ccff_commit are asserted in the same cycle, commit the pre-shift shadow contents; on acceptance the counter becomes 1.
REQ-022 SHALL generate the pad outputs combinationally from the active config:
  - gfpga_pad_io_soc_dir[p] = dir[p] OR NOT isol_n
  - gfpga_pad_io_soc_out[p] = isol_n AND NOT dir[p] AND (pin_outpad[p] XOR inv[p])
  - pin_inpad[p] = isol_n AND dir[p] AND (gfpga_pad_io_soc_in[p] XOR inv[p])
REQ-023 SHALL ensure isol_n=0 overrides the active configuration without altering any register.

Reset
REQ-024 SHALL, while prog_reset_n=0, asynchronously set: shadow = 0, counter = 0, cfg_err = 0, all dir = 1, all inv = 0.
REQ-025 SHALL, during reset, therefore present: ccff_tail = 0, cfg_done = 0, gfpga_pad_io_soc_dir = all-1, gfpga_pad_io_soc_out = 0, pin_inpad = 0 when isol_n=1 and gfpga_pad_io_soc_in=0.
REQ-026 SHALL, on reset assertion mid-shift or mid-commit, discard the partial frame; the active config returns to its reset values.
REQ-027 SHALL take reset release synchronously into account: the first shift occurs on the first edge with prog_reset_n=1.

Configuration
REQ-028 SHALL, with GRID_IO_CFG_PARITY_EN defined, append one parity bit at shadow[LEN-1]; a commit is accepted only if the XOR of all LEN shadow bits is 0 (even parity), and is otherwise rejected per REQ-020.
REQ-029 SHALL, without GRID_IO_CFG_PARITY_EN, have no parity bit, with LEN = NUM_PADS*CFG_BITS and cfg_err set only by a commit issued with cfg_done=0.

Verification
REQ-030 SHALL cover reset defaults: NUM_PADS=4, isol_n=1, soc_in=4'b1010 -> soc_dir=4'b1111, soc_out=0, pin_inpad=4'b1010, cfg_done=0.
REQ-031 SHALL cover output configuration: shift 8 bits so all pads have dir=0, inv=0, then commit -> cfg_done=1 before the commit and 0 after; soc_dir=0; pin_outpad=4'b0110 gives soc_out=4'b0110.
REQ-032 SHALL cover inversion: configure pad 2 with dir=1, inv=1 and commit; soc_in[2]=0 -> pin_inpad[2]=1.
REQ-033 SHALL cover an early commit: commit after 5 shifts -> cfg_err=1 and outputs unchanged; 3 more shifts then a commit -> accepted and cfg_err=0.
REQ-034 SHALL cover isolation and simultaneous events: isol_n=0 -> soc_dir=all-1, soc_out=0, pin_inpad=0 with registers unchanged; shift_en and commit in the same cycle -> pre-shift data committed and counter=1.
REQ-035 SHALL cover parity (GRID_IO_CFG_PARITY_EN defined): a 9-bit frame with odd parity -> commit rejected and cfg_err=1; corrected frame -> accepted; asserting reset mid-frame -> counter=0 and dir all-1.

Source files
------------

// File: rtl/grid_io_param.sv
// ---------------------------------------------------------------------------
// grid_io_param
//
// Configurable I/O tile holding NUM_PADS bidirectional pads. Configuration
// is loaded serially into a shadow chain and copied into the active
// configuration by a commit. A commit is accepted only after a full frame
// has been shifted in since the last accepted commit.
//
// Optional feature macro: GRID_IO_CFG_PARITY_EN
//   When this macro is defined, one even-parity bit is appended at the top of
//   the shadow chain. A commit is then also rejected unless the XOR of the
//   whole chain is 0.
//
// Parameters
//   NUM_PADS  number of pad subtiles (1..32)
//   CFG_BITS  configuration bits per pad (fixed at 2: bit0 = dir, bit1 = inv)
//
// Ports
//   prog_clk              clock; all state updates on its rising edge
//   prog_reset_n          asynchronous active-low reset
//   isol_n                active-low isolation; forces pads to a safe state
//   ccff_head             serial configuration data in
//   ccff_shift_en         shift the shadow chain this cycle
//   ccff_commit           request shadow -> active copy
//   ccff_tail             last bit of the shadow chain
//   gfpga_pad_io_soc_in   pad-side input   [NUM_PADS]
//   gfpga_pad_io_soc_out  pad-side output  [NUM_PADS]
//   gfpga_pad_io_soc_dir  pad direction, 1 = input [NUM_PADS]
//   pin_outpad            fabric-side data toward the pads [NUM_PADS]
//   pin_inpad             fabric-side data from the pads   [NUM_PADS]
//   cfg_done              a full frame is sitting in the shadow chain
//   cfg_err               sticky: last commit attempt was rejected
// ---------------------------------------------------------------------------
module grid_io_param #(
   parameter int NUM_PADS = 4,
   parameter int CFG_BITS = 2
) (
   input  logic                prog_clk,
   input  logic                prog_reset_n,
   input  logic                isol_n,
   input  logic                ccff_head,
   input  logic                ccff_shift_en,
   input  logic                ccff_commit,
   output logic                ccff_tail,
   input  logic [NUM_PADS-1:0] gfpga_pad_io_soc_in,
   output logic [NUM_PADS-1:0] gfpga_pad_io_soc_out,
   output logic [NUM_PADS-1:0] gfpga_pad_io_soc_dir,
   input  logic [NUM_PADS-1:0] pin_outpad,
   output logic [NUM_PADS-1:0] pin_inpad,
   output logic                cfg_done,
   output logic                cfg_err
);

   localparam int DATA_LEN = NUM_PADS * CFG_BITS;
`ifdef GRID_IO_CFG_PARITY_EN
   localparam int LEN = DATA_LEN + 1;
`else
   localparam int LEN = DATA_LEN;
`endif
   localparam int CW = $clog2(LEN + 1);
   localparam logic [CW-1:0] LEN_C     = CW'(LEN);
   localparam logic [CW-1:0] LEN_M1_C  = CW'(LEN - 1);

   logic [LEN-1:0]      shadow;
   // Down-counter of bits still needed for a full frame; the externally
   // visible "bit counter" equals LEN - bits_left, and it saturates at 0.
   logic [CW-1:0]       bits_left;
   logic [NUM_PADS-1:0] dir_q;
   logic [NUM_PADS-1:0] inv_q;
   logic                cfg_err_q;
   logic                parity_ok;
   logic                commit_ok;

`ifdef GRID_IO_CFG_PARITY_EN
   assign parity_ok = ~(^shadow);
`else
   assign parity_ok = 1'b1;
`endif

   assign cfg_done  = (bits_left == '0);
   assign commit_ok = ccff_commit & cfg_done & parity_ok;
   assign ccff_tail = shadow[LEN-1];
   assign cfg_err   = cfg_err_q;

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         shadow    <= '0;
         bits_left <= LEN_C;
         cfg_err_q <= 1'b0;
         dir_q     <= '1;
         inv_q     <= '0;
      end else begin
         if (ccff_shift_en)
            shadow <= {shadow[LEN-2:0], ccff_head};

         // A commit coinciding with a shift takes the pre-shift frame, and
         // the bit shifted in that cycle already counts toward the next one.
         if (commit_ok)
            bits_left <= ccff_shift_en ? LEN_M1_C : LEN_C;
         else if (ccff_shift_en && bits_left != '0)
            bits_left <= bits_left - 1'b1;

         if (commit_ok) begin
            cfg_err_q <= 1'b0;
            for (int p = 0; p < NUM_PADS; p++) begin
               dir_q[p] <= shadow[2*p];
               inv_q[p] <= shadow[2*p+1];
            end
         end else if (ccff_commit) begin
            cfg_err_q <= 1'b1;
         end
      end
   end

   // Isolation overrides the active configuration on the outputs only.
   always_comb begin
      gfpga_pad_io_soc_dir = '0;
      gfpga_pad_io_soc_out = '0;
      pin_inpad            = '0;
      for (int p = 0; p < NUM_PADS; p++) begin
         gfpga_pad_io_soc_dir[p] = dir_q[p] | ~isol_n;
         gfpga_pad_io_soc_out[p] = isol_n & ~dir_q[p] & (pin_outpad[p] ^ inv_q[p]);
         pin_inpad[p]            = isol_n & dir_q[p] & (gfpga_pad_io_soc_in[p] ^ inv_q[p]);
      end
   end

endmodule

// File: tb/tb_grid_io_param.sv
// ---------------------------------------------------------------------------
// tb_grid_io_param
//
// Directed bench for grid_io_param with NUM_PADS = 4. Inputs change 1 ns
// after the rising edge and outputs are checked there, away from the edge.
// ---------------------------------------------------------------------------
module tb_grid_io_param;

   localparam int NP = 4;
`ifdef GRID_IO_CFG_PARITY_EN
   localparam int LEN = 9;
`else
   localparam int LEN = 8;
`endif

   logic          prog_clk = 1'b0;
   logic          prog_reset_n;
   logic          isol_n;
   logic          ccff_head;
   logic          ccff_shift_en;
   logic          ccff_commit;
   logic          ccff_tail;
   logic [NP-1:0] soc_in;
   logic [NP-1:0] soc_out;
   logic [NP-1:0] soc_dir;
   logic [NP-1:0] pin_outpad;
   logic [NP-1:0] pin_inpad;
   logic          cfg_done;
   logic          cfg_err;

   int n_checks = 0;
   int n_fail   = 0;

   grid_io_param #(.NUM_PADS(NP), .CFG_BITS(2)) dut (
      .prog_clk             (prog_clk),
      .prog_reset_n         (prog_reset_n),
      .isol_n               (isol_n),
      .ccff_head            (ccff_head),
      .ccff_shift_en        (ccff_shift_en),
      .ccff_commit          (ccff_commit),
      .ccff_tail            (ccff_tail),
      .gfpga_pad_io_soc_in  (soc_in),
      .gfpga_pad_io_soc_out (soc_out),
      .gfpga_pad_io_soc_dir (soc_dir),
      .pin_outpad           (pin_outpad),
      .pin_inpad            (pin_inpad),
      .cfg_done             (cfg_done),
      .cfg_err              (cfg_err)
   );

   always #5 prog_clk = ~prog_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge prog_clk);
      #1;
   endtask

   // Frame with data bits in [7:0]; parity bit on top when enabled.
   function automatic logic [LEN-1:0] frame(input logic [7:0] data);
      logic [LEN-1:0] f;
      f = '0;
      f[7:0] = data;
`ifdef GRID_IO_CFG_PARITY_EN
      f[LEN-1] = ^data;
`endif
      return f;
   endfunction

   // Shift bits v[hi] down to v[lo]; the first bit shifted ends up highest.
   task automatic shift_range(input logic [LEN-1:0] v, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         ccff_head     = v[i];
         ccff_shift_en = 1'b1;
         step();
      end
      ccff_shift_en = 1'b0;
      ccff_head     = 1'b0;
   endtask

   task automatic commit();
      ccff_commit = 1'b1;
      step();
      ccff_commit = 1'b0;
   endtask

   task automatic shift_zeros(input int n);
      for (int i = 0; i < n; i++) begin
         ccff_head     = 1'b0;
         ccff_shift_en = 1'b1;
         step();
      end
      ccff_shift_en = 1'b0;
   endtask

   logic [LEN-1:0] v;

   initial begin
      prog_reset_n  = 1'b0;
      isol_n        = 1'b1;
      ccff_head     = 1'b0;
      ccff_shift_en = 1'b0;
      ccff_commit   = 1'b0;
      soc_in        = 4'b1010;
      pin_outpad    = 4'b0000;

      // Reset defaults
      step();
      step();
      check("rst_dir",    soc_dir,   4'b1111);
      check("rst_out",    soc_out,   4'b0000);
      check("rst_inpad",  pin_inpad, 4'b1010);
      check("rst_done",   cfg_done,  1'b0);
      check("rst_tail",   ccff_tail, 1'b0);
      check("rst_err",    cfg_err,   1'b0);
      prog_reset_n = 1'b1;

      // All pads output, no inversion
      v = frame(8'h00);
      shift_range(v, LEN-1, 1);
      check("out_done_early", cfg_done, 1'b0);
      shift_range(v, 0, 0);
      check("out_done_full",  cfg_done, 1'b1);
      check("out_dir_precommit", soc_dir, 4'b1111);
      pin_outpad = 4'b0110;
      commit();
      check("out_done_after", cfg_done, 1'b0);
      check("out_dir",   soc_dir,   4'b0000);
      check("out_out",   soc_out,   4'b0110);
      check("out_inpad", pin_inpad, 4'b0000);
      check("out_err",   cfg_err,   1'b0);

      // Pad 2 input with inversion, others output
      v = frame(8'h30);
      shift_range(v, LEN-1, 0);
      commit();
      soc_in     = 4'b0000;
      pin_outpad = 4'b1111;
      #1;
      check("inv_dir",   soc_dir,   4'b0100);
      check("inv_inpad", pin_inpad, 4'b0100);
      check("inv_out",   soc_out,   4'b1011);
      soc_in = 4'b0100;
      #1;
      check("inv_inpad_hi", pin_inpad, 4'b0000);

      // Early commit rejected, completed frame accepted
      v = frame(8'h55);
      shift_range(v, LEN-1, LEN-5);
      commit();
      check("early_err",  cfg_err,  1'b1);
      check("early_dir",  soc_dir,  4'b0100);
      check("early_done", cfg_done, 1'b0);
      shift_range(v, LEN-6, 0);
      check("late_done",  cfg_done, 1'b1);
      commit();
      soc_in = 4'b1010;
      #1;
      check("late_err",   cfg_err,   1'b0);
      check("late_dir",   soc_dir,   4'b1111);
      check("late_inpad", pin_inpad, 4'b1010);

      // Isolation overrides outputs, registers untouched
      isol_n = 1'b0;
      #1;
      check("iso_dir",   soc_dir,   4'b1111);
      check("iso_out",   soc_out,   4'b0000);
      check("iso_inpad", pin_inpad, 4'b0000);
      isol_n = 1'b1;
      #1;
      check("iso_release_inpad", pin_inpad, 4'b1010);
      check("iso_release_err",   cfg_err,   1'b0);

      // Simultaneous shift and commit: pre-shift frame committed, counter = 1
      v = frame(8'h00);
      shift_range(v, LEN-1, 0);
      ccff_head     = 1'b1;
      ccff_shift_en = 1'b1;
      ccff_commit   = 1'b1;
      step();
      ccff_commit   = 1'b0;
      ccff_shift_en = 1'b0;
      ccff_head     = 1'b0;
      check("sim_dir",  soc_dir,  4'b0000);
      check("sim_done", cfg_done, 1'b0);
      check("sim_err",  cfg_err,  1'b0);
      shift_zeros(LEN-2);
      check("sim_cnt_short", cfg_done, 1'b0);
      shift_zeros(1);
      check("sim_cnt_full",  cfg_done, 1'b1);
      shift_zeros(3);
      check("sat_done", cfg_done, 1'b1);
      commit();
      check("sat_commit_done", cfg_done, 1'b0);
      check("sat_commit_dir",  soc_dir,  4'b0000);

      // Reset mid-frame discards partial frame and active config
      shift_range('1, 2, 0);
      #2;
      prog_reset_n = 1'b0;
      #1;
      check("midrst_dir",  soc_dir,   4'b1111);
      check("midrst_done", cfg_done,  1'b0);
      check("midrst_tail", ccff_tail, 1'b0);
      step();
      prog_reset_n = 1'b1;
      v = '0;
      v[LEN-1] = 1'b1;
      shift_range(v, LEN-1, 1);
      check("tail_before", ccff_tail, 1'b0);
      check("cnt_before",  cfg_done,  1'b0);
      shift_range(v, 0, 0);
      check("tail_after",  ccff_tail, 1'b1);
      check("cnt_after",   cfg_done,  1'b1);

`ifdef GRID_IO_CFG_PARITY_EN
      // Odd-parity frame rejected, corrected frame accepted
      prog_reset_n = 1'b0;
      step();
      prog_reset_n = 1'b1;
      v = {1'b1, 8'h00};
      shift_range(v, LEN-1, 0);
      check("par_bad_done", cfg_done, 1'b1);
      commit();
      check("par_bad_err", cfg_err, 1'b1);
      check("par_bad_dir", soc_dir, 4'b1111);
      v = frame(8'h01);
      shift_range(v, LEN-1, 0);
      commit();
      check("par_good_err", cfg_err, 1'b0);
      check("par_good_dir", soc_dir, 4'b0001);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
